// File: rtl/count_uart_pkg.sv
// count_uart_pkg: shared types and constants for the counter UART transmitter.
package count_uart_pkg;
    localparam int DATA_W = 8;
    localparam logic TX_IDLE_LVL = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/count_uart_tx_if.sv
// count_uart_tx_if: valid/ready byte handshake feeding the UART transmitter.
interface count_uart_tx_if import count_uart_pkg::*; ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/count_uart_baud.sv
// count_uart_baud: bit-cycle counter, pulses bit_done on the last cycle of each UART bit.
module count_uart_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (clear || bit_done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/count_uart_tx.sv
// count_uart_tx: 8N1 LSB-first UART transmitter with valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module count_uart_tx import count_uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    count_uart_tx_if.slave   bus,
    output logic             tx,
    output logic             busy
);
    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [2:0]        idx, idx_nxt;
    logic              tx_nxt;
    logic              bit_done;
    count_uart_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );
    assign bus.in_ready = state == IDLE;
    assign busy         = state != IDLE;
`ifdef UART_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              par <= 1'b0;
        else if (state == IDLE && bus.in_valid)  par <= ^bus.in_data;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            tx    <= TX_IDLE_LVL;
        end else begin
            state <= state_nxt;
            shift <= shift_nxt;
            idx   <= idx_nxt;
            tx    <= tx_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        idx_nxt   = idx;
        case (state)
            IDLE: if (bus.in_valid) begin
                state_nxt = START;
                shift_nxt = bus.in_data;
                idx_nxt   = '0;
            end
            START: if (bit_done) state_nxt = DATA;
            DATA: if (bit_done) begin
                shift_nxt = shift >> 1;
                idx_nxt   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (idx == 3'd7) state_nxt = PARITY;
`else
                if (idx == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_nxt = STOP;
`endif
            STOP: if (bit_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // tx is registered, so it is derived from the state being entered
        tx_nxt = state_nxt == START ? 1'b0 :
                 state_nxt == DATA  ? shift_nxt[0] : TX_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
        if (state_nxt == PARITY) tx_nxt = par;
`endif
    end
endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx: scoreboard bench for count_uart_tx at CLKS_PER_BIT=4.
// Define UART_TX_PARITY_EN to exercise the parity build.
module tb_count_uart_tx;
    import count_uart_pkg::*;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11 * C;
`else
    localparam int FL = 10 * C;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy;
    int n_tests = 0;
    int n_fail = 0;
    logic exp_q[$];
    logic mon_e;
    count_uart_tx_if bus ();
    count_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .tx    (tx),
        .busy  (busy)
    );
    always #5 clk = ~clk;
    // one expected tx level per clock cycle, consumed on every falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (tx !== mon_e) begin
                n_fail++;
                $display("FAIL tx_stream: tx=%b expected %b at %0t", tx, mon_e, $time);
            end
        end
    end
    function automatic void push_frame(input logic [7:0] d);
        for (int i = 0; i < C; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < C; i++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < C; i++) exp_q.push_back(^d);
`endif
        for (int i = 0; i < C; i++) exp_q.push_back(1'b1);
    endfunction
    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%b expected 1", bus.in_ready);
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        push_frame(d);
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        n_tests += 3;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: in_ready=%b expected 1", bus.in_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask
    task automatic test_single();
        int hi;
        hi = 0;
        send(8'hA5);
        bus.in_valid = 1'b0;
        for (int i = 0; i < FL + 5; i++) begin
            @(negedge clk);
            if (busy === 1'b1) hi++;
        end
        n_tests += 3;
        if (hi != FL) begin n_fail++; $display("FAIL single_busy_len: busy cycles=%0d expected %0d", hi, FL); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: in_ready=%b expected 1", bus.in_ready); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: queue=%0d expected 0", exp_q.size()); end
    endtask
    task automatic test_back_to_back();
        send(8'h00);
        bus.in_data = 8'hFF;
        exp_q.push_back(1'b1);
        push_frame(8'hFF);
        for (int i = 1; i <= 2 * FL + 1; i++) begin
            @(negedge clk);
            if (i == FL + 1) begin
                n_tests += 2;
                if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_tx: tx=%b expected 1", tx); end
                if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy: busy=%b expected 0", busy); end
            end
            if (i == FL + 2) begin
                n_tests += 2;
                if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start_tx: tx=%b expected 0", tx); end
                if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_busy: busy=%b expected 1", busy); end
            end
            if (i == 2 * FL + 1) bus.in_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        n_tests += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: busy=%b expected 0", busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: queue=%0d expected 0", exp_q.size()); end
    endtask
    task automatic test_data_change();
        send(8'hA5);
        bus.in_valid = 1'b0;
        repeat (5 * C) @(negedge clk);
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (FL) @(negedge clk);
        n_tests += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL change_busy: busy=%b expected 0", busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL change_drain: queue=%0d expected 0", exp_q.size()); end
    endtask
    task automatic test_async_reset();
        send(8'h00);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        n_tests += 3;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL async_tx: tx=%b expected 1", tx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: busy=%b expected 0", busy); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: in_ready=%b expected 1", bus.in_ready); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL async_hold_tx: tx=%b expected 1", tx); end
        rst_n = 1'b1;
    endtask
    task automatic test_reset_mid_frame();
        send(8'hA5);
        bus.in_valid = 1'b0;
        repeat (22) @(negedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        n_tests += 2;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx: tx=%b expected 1", tx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: busy=%b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h5A);
        bus.in_valid = 1'b0;
        repeat (FL + 2) @(negedge clk);
        n_tests += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_next_busy: busy=%b expected 0", busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_next_drain: queue=%0d expected 0", exp_q.size()); end
    endtask
`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] pats [2];
        logic       pbit [2];
        int hi;
        pats[0] = 8'hA5; pbit[0] = 1'b0;
        pats[1] = 8'h01; pbit[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            hi = 0;
            send(pats[k]);
            bus.in_valid = 1'b0;
            for (int i = 1; i <= FL + 4; i++) begin
                @(negedge clk);
                if (busy === 1'b1) hi++;
                if (i == 9 * C + 2) begin
                    n_tests++;
                    if (tx !== pbit[k]) begin n_fail++; $display("FAIL parity_bit: data=%h tx=%b expected %b", pats[k], tx, pbit[k]); end
                end
            end
            n_tests++;
            if (hi != 11 * C) begin n_fail++; $display("FAIL parity_len: busy cycles=%0d expected %0d", hi, 11 * C); end
        end
    endtask
`endif
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_data_change();
        test_async_reset();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_drain: queue=%0d expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
